sa_input_queue_4x4: RTL
=======================

# sa_input_queue_4x4

Four-port input-buffering stage that sits directly upstream of the root 4x4 switch allocator. It holds flits from four independent ingress ports in per-port FIFOs and presents one request bit per non-empty port to the allocator. On each acknowledge it pops the granted port's head flit and forwards it, registered, on a single egress bus tagged with its source port.

## Interface
- DATA_W, 32, flit payload width in bits.
- DEPTH, 4, entries per port FIFO; power of two, ≥2.

- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  4  per-port push request.
- in_data  in  4×DATA_W  per-port payload; index i is port i.
- in_ready  out  4  per-port FIFO not full.
- req  out  4  per-port request to the allocator; bit i means FIFO i is non-empty.
- ack  in  4  per-port grant from the allocator, same-cycle combinational response to req.
- out_valid  out  1  egress flit valid, one-cycle pulse per pop.
- out_data  out  DATA_W  egress payload.
- out_port  out  2  source port of the egress flit.
- err_multi_ack  out  1  sticky flag: ack was seen with more than one bit set.

## Operation
- Per port i: FIFO with registered count (0..DEPTH), read pointer and write pointer, each log2(DEPTH) bits, wrapping modulo DEPTH.
- Push: in_valid[i] & in_ready[i] writes in_data[i] at wr_ptr and advances wr_ptr.
- in_ready[i] = (count_i != DEPTH). There is no push-when-full, even if a pop happens in the same cycle.
- req[i] = (count_i != 0). It is driven only from registered state, so the allocator's combinational ack path has no loop.
- Pop: the effective grant is ack & req. If it is non-zero, select the lowest set index g:
  - read FIFO g head, advance its rd_ptr;
  - next cycle: out_valid=1, out_data=head, out_port=g.
- If the effective grant is zero, out_valid=0 next cycle, and out_data/out_port hold their previous values.
- ack[i] with req[i]=0 is ignored: no pop, no error.
- If ack has two or more bits set, only the lowest granted index pops, and err_multi_ack goes to 1 and stays there until reset.
- Simultaneous push and pop on the same port: count unchanged, both pointers advance.
- There is no egress backpressure. The downstream consumer must accept every out_valid pulse.

## Timing
- Reset values: all counts and pointers 0, in_ready=4'b1111, req=4'b0000, out_valid=0, out_data=0, out_port=0, err_multi_ack=0.
- Reset asserted mid-operation discards all queued flits immediately (asynchronous), including any pending egress pulse.
- Push accepted in cycle N: count increments and req rises in cycle N+1.
- Ack in cycle N+1: out_valid pulses in cycle N+2.
- Minimum ingress-to-egress latency is 2 cycles.
- Pop in cycle N: count decrements in N+1, and req drops in N+1 if the FIFO became empty.
- Sustained throughput: one egress flit per cycle across all ports, one pop per port per cycle.

## Structure
- Shared package sa_pkg holds:
  - NUM_PORTS=4;
  - typedef port_id_t (logic [1:0]);
  - the DEPTH/DATA_W defaults, so the allocator and this block agree.
- Sub-module sa_port_fifo, one instance per port. It has push/pop, count, head data, full and empty outputs.
- The top level contains the grant selection (lowest set bit of ack & req), the egress registers and the error flag.

## Test plan
- Reset, then idle: in_ready=4'hF, req=0, out_valid=0 with ack forced to 4'hF; err_multi_ack stays 0.
- Push 0xA0..0xA3 on port 2, then ack=4'b0100 for 4 cycles: out_data=0xA0,0xA1,0xA2,0xA3 in order, out_port=2, req[2] falls the cycle after the 4th pop.
- Fill port 0 to DEPTH=4: in_ready[0]=0. A 5th push is not accepted. Push and pop 8 flits continuously: pointers wrap and FIFO order is preserved.
- Ports 1 and 3 non-empty, ack=4'b1010: only port 1 pops, out_port=1, err_multi_ack=1 and stays set.
- ack=4'b0001 while port 0 is empty: no pop, out_valid=0, no error.
- Deassert rst_n asynchronously with 3 flits queued on port 3: req and count clear at once, and no out_valid follows after release.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared allocator definitions: port count, port id type and default FIFO geometry,
// so the allocator and its input queues agree on widths.
package sa_pkg;

  localparam int NUM_PORTS  = 4;
  localparam int DEPTH_DEF  = 4;
  localparam int DATA_W_DEF = 32;

  typedef logic [1:0] port_id_t;

  // Index of the lowest set bit; returns 0 for an all-zero vector.
  function automatic port_id_t lowest_idx(input logic [NUM_PORTS-1:0] v);
    port_id_t idx;
    idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (v[i]) idx = port_id_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sa_port_fifo.sv
// Single-port flit FIFO with registered count and wrapping pointers.
// Caller must gate push with !full and pop with !empty; the head is read combinationally.
module sa_port_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [CNT_W-1:0]  o_count,
  output logic [DATA_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/sa_input_queue_4x4.sv
// Four per-port input FIFOs feeding the 4x4 switch allocator; pops the lowest granted
// port on ack and drives a registered egress flit one cycle later (no egress backpressure).
module sa_input_queue_4x4
  import sa_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             in_valid,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] in_data,
  output logic [NUM_PORTS-1:0]             in_ready,
  output logic [NUM_PORTS-1:0]             req,
  input  logic [NUM_PORTS-1:0]             ack,
  output logic                             out_valid,
  output logic [DATA_W-1:0]                out_data,
  output port_id_t                         out_port,
  output logic                             err_multi_ack
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NUM_PORTS-1:0][CNT_W-1:0]  w_count;
  logic [NUM_PORTS-1:0][DATA_W-1:0] w_head;
  logic [NUM_PORTS-1:0]             w_full;
  logic [NUM_PORTS-1:0]             w_empty;
  logic [NUM_PORTS-1:0]             w_push;
  logic [NUM_PORTS-1:0]             w_eff;
  logic [NUM_PORTS-1:0]             w_pop;
  logic                             w_multi;
  port_id_t                         w_sel;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  port_id_t          r_out_port;
  logic              r_err;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    sa_port_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push[g]),
      .i_pop   (w_pop[g]),
      .i_data  (in_data[g]),
      .o_count (w_count[g]),
      .o_head  (w_head[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
    assign req[g] = (w_count[g] != '0);
  end

  // Full blocks push even when the same port pops this cycle.
  assign in_ready = ~w_full;
  assign w_push   = in_valid & ~w_full;

  assign w_eff   = ack & ~w_empty;
  assign w_sel   = lowest_idx(w_eff);
  assign w_pop   = (w_eff != '0) ? (NUM_PORTS'(1) << w_sel) : '0;
  assign w_multi = ((w_eff & (w_eff - NUM_PORTS'(1))) != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_port  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= (w_eff != '0);
      if (w_eff != '0) begin
        r_out_data <= w_head[w_sel];
        r_out_port <= w_sel;
      end
      if (w_multi) r_err <= 1'b1;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign out_port      = r_out_port;
  assign err_multi_ack = r_err;

endmodule
